// File: rtl/bus_demux_waitgen.sv
// rtl/bus_demux_waitgen.sv - 8088 bus demux, address latch and wait-state generator
module bus_demux_waitgen #(
  parameter int WAIT_MEM = 1,
  parameter int WAIT_IO  = 2,
  parameter int TIMEOUT  = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [19:0] a,
  inout  wire  [7:0]  ad,
  input  logic        ale,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic        den_n,
  input  logic        iom,
  output logic        ready,
  output logic [19:0] mem_adr,
  output logic        mem_io,
  output logic        mem_we,
  output logic [7:0]  mem_dat_o,
  output logic        mem_stb,
  input  logic [7:0]  mem_dat_i,
  input  logic        mem_ack,
  output logic        bus_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LATCHED = 2'd1,
    ACCESS  = 2'd2,
    FINISH  = 2'd3
  } state_t;

  localparam logic [8:0] WAIT_MEM_W = 9'(WAIT_MEM);
  localparam logic [8:0] WAIT_IO_W  = 9'(WAIT_IO);
  localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT - 1);

  state_t     state;
  logic [7:0] cnt;
  logic       ack_seen;
  logic [7:0] rdata;
  logic       ad_oe;
  logic       ack_now;
  logic       wait_met;
  logic [8:0] wait_sel;
  logic [8:0] cnt_next;

  // Only the first ack of an access counts; later ones are ignored.
  assign ack_now  = mem_ack && !ack_seen;
  assign wait_sel = mem_io ? WAIT_IO_W : WAIT_MEM_W;
  assign cnt_next = {1'b0, cnt} + 9'd1;
  assign wait_met = cnt_next >= wait_sel;

  // Read data goes back onto the CPU bus only in FINISH of a read cycle.
  assign ad_oe = (state == FINISH) && !mem_we && !rd_n && !den_n;
  assign ad    = ad_oe ? rdata : 8'bz;

  // Bus-cycle state machine; every output is registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ready     <= 1'b1;
      mem_stb   <= 1'b0;
      mem_we    <= 1'b0;
      mem_io    <= 1'b0;
      mem_adr   <= 20'd0;
      mem_dat_o <= 8'd0;
      rdata     <= 8'd0;
      bus_err   <= 1'b0;
      cnt       <= 8'd0;
      ack_seen  <= 1'b0;
    end else begin
      bus_err <= 1'b0;
      case (state)
        IDLE, LATCHED, FINISH: begin
          if (ale) begin
            mem_adr <= {a[19:8], ad};
            mem_io  <= iom;
            state   <= LATCHED;
          end else if (state == LATCHED) begin
            if (!rd_n && !wr_n) begin
              bus_err <= 1'b1;
              state   <= IDLE;
            end else if (!rd_n && !den_n) begin
              mem_we   <= 1'b0;
              mem_stb  <= 1'b1;
              ready    <= 1'b0;
              cnt      <= 8'd0;
              ack_seen <= 1'b0;
              state    <= ACCESS;
            end else if (!wr_n && !den_n) begin
              mem_we    <= 1'b1;
              mem_dat_o <= ad;
              mem_stb   <= 1'b1;
              ready     <= 1'b0;
              cnt       <= 8'd0;
              ack_seen  <= 1'b0;
              state     <= ACCESS;
            end
          end else if (state == FINISH && rd_n && wr_n) begin
            state <= IDLE;
          end
        end
        ACCESS: begin
          if (ack_now) begin
            ack_seen <= 1'b1;
            mem_stb  <= 1'b0;
            if (!mem_we) rdata <= mem_dat_i;
          end
          if ((ack_seen || ack_now) && wait_met) begin
            mem_stb <= 1'b0;
            ready   <= 1'b1;
            state   <= FINISH;
          end else if (!ack_seen && !ack_now && cnt == TMO_LAST) begin
            mem_stb <= 1'b0;
            rdata   <= 8'hFF;
            bus_err <= 1'b1;
            ready   <= 1'b1;
            state   <= FINISH;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_demux_waitgen.sv
// tb/tb_bus_demux_waitgen.sv - directed self-checking bench for bus_demux_waitgen
module tb_bus_demux_waitgen;

  logic        clk = 1'b0;
  logic        rst;
  logic [19:0] a;
  wire  [7:0]  ad;
  logic        ale, rd_n, wr_n, den_n, iom;
  logic        ready;
  logic [19:0] mem_adr;
  logic        mem_io, mem_we, mem_stb, mem_ack, bus_err;
  logic [7:0]  mem_dat_o, mem_dat_i;
  logic [7:0]  tb_drv;
  logic        tb_oe;

  int n_chk  = 0;
  int n_pass = 0;
  int low_c, stb_c;
  logic err_c;

  assign ad = tb_oe ? tb_drv : 8'bz;

  always #5 clk = ~clk;

  bus_demux_waitgen dut (
    .clk(clk), .rst(rst), .a(a), .ad(ad), .ale(ale), .rd_n(rd_n), .wr_n(wr_n),
    .den_n(den_n), .iom(iom), .ready(ready), .mem_adr(mem_adr), .mem_io(mem_io),
    .mem_we(mem_we), .mem_dat_o(mem_dat_o), .mem_stb(mem_stb),
    .mem_dat_i(mem_dat_i), .mem_ack(mem_ack), .bus_err(bus_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic latch(input logic [19:0] adr, input logic io);
    a = {adr[19:8], 8'h00}; tb_drv = adr[7:0]; tb_oe = 1'b1; iom = io; ale = 1'b1;
    cyc();
    ale = 1'b0; tb_oe = 1'b0;
  endtask

  // Counts ready-low and strobe-high cycles; ack pulses on ACCESS cycle index lat (-1 = never).
  task automatic run_access(input int lat, input logic [7:0] dat,
                            output int low, output int stb, output logic err);
    low = 0; stb = 0;
    for (int i = 0; i < 40; i++) begin
      if (ready) break;
      low++;
      if (mem_stb) stb++;
      mem_ack = (i == lat);
      mem_dat_i = dat;
      cyc();
    end
    mem_ack = 1'b0;
    err = bus_err;
    if (!ready) check("access_bound", 32'(ready), 32'd1);
  endtask

  task automatic start_read;
    rd_n = 1'b0; den_n = 1'b0;
    cyc();
  endtask

  task automatic end_cycle;
    rd_n = 1'b1; wr_n = 1'b1; den_n = 1'b1; tb_oe = 1'b0;
    cyc();
  endtask

  initial begin
    rst = 1'b1; a = '0; ale = 0; rd_n = 1; wr_n = 1; den_n = 1; iom = 0;
    mem_ack = 0; mem_dat_i = '0; tb_drv = '0; tb_oe = 0;
    cyc(); cyc();
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_stb", 32'(mem_stb), 32'd0);
    check("rst_adr", 32'(mem_adr), 32'd0);
    check("rst_err", 32'(bus_err), 32'd0);
    check("rst_ad_oe", 32'(dut.ad_oe), 32'd0);
    rst = 1'b0;
    cyc();

    // memory read, zero-latency slave
    latch(20'hF0034, 1'b0);
    check("rd_adr", 32'(mem_adr), 32'hF0034);
    check("rd_ready_latched", 32'(ready), 32'd1);
    start_read();
    check("rd_stb_on", 32'(mem_stb), 32'd1);
    run_access(0, 8'hA5, low_c, stb_c, err_c);
    check("rd_low", 32'(low_c), 32'd1);
    check("rd_stb_cyc", 32'(stb_c), 32'd1);
    check("rd_ad", 32'(ad), 32'hA5);
    check("rd_ad_oe", 32'(dut.ad_oe), 32'd1);
    end_cycle();
    check("rd_idle_ad_oe", 32'(dut.ad_oe), 32'd0);

    // IO write, immediate ack, two wait states
    latch(20'h12377, 1'b1);
    wr_n = 1'b0; den_n = 1'b0; tb_drv = 8'h5A; tb_oe = 1'b1;
    cyc();
    check("wr_we", 32'(mem_we), 32'd1);
    check("wr_dat", 32'(mem_dat_o), 32'h5A);
    check("wr_io", 32'(mem_io), 32'd1);
    check("wr_adr", 32'(mem_adr), 32'h12377);
    run_access(0, 8'h00, low_c, stb_c, err_c);
    check("wr_low", 32'(low_c), 32'd2);
    check("wr_stb_cyc", 32'(stb_c), 32'd1);
    check("wr_ad_oe", 32'(dut.ad_oe), 32'd0);
    end_cycle();

    // slow slave: ack on the 6th strobe cycle
    latch(20'h00100, 1'b0);
    start_read();
    run_access(5, 8'h3C, low_c, stb_c, err_c);
    check("slow_low", 32'(low_c), 32'd6);
    check("slow_stb_cyc", 32'(stb_c), 32'd6);
    check("slow_ad", 32'(ad), 32'h3C);
    check("slow_err", 32'(err_c), 32'd0);
    end_cycle();

    // absent slave: timeout
    latch(20'h00200, 1'b0);
    start_read();
    run_access(-1, 8'h00, low_c, stb_c, err_c);
    check("tmo_low", 32'(low_c), 32'd15);
    check("tmo_stb_cyc", 32'(stb_c), 32'd15);
    check("tmo_err", 32'(err_c), 32'd1);
    check("tmo_stb_off", 32'(mem_stb), 32'd0);
    check("tmo_ad", 32'(ad), 32'hFF);
    cyc();
    check("tmo_err_pulse", 32'(bus_err), 32'd0);
    end_cycle();

    // rd_n and wr_n both low in LATCHED
    latch(20'h00300, 1'b0);
    rd_n = 1'b0; wr_n = 1'b0; den_n = 1'b0;
    cyc();
    check("proto_err", 32'(bus_err), 32'd1);
    check("proto_stb", 32'(mem_stb), 32'd0);
    cyc();
    check("proto_err_pulse", 32'(bus_err), 32'd0);
    check("proto_stb2", 32'(mem_stb), 32'd0);
    end_cycle();

    // reset during the 3rd ACCESS cycle
    latch(20'h00400, 1'b0);
    start_read();
    cyc(); cyc();
    check("rst_mid_stb_before", 32'(mem_stb), 32'd1);
    rst = 1'b1;
    #1;
    check("rst_mid_stb", 32'(mem_stb), 32'd0);
    check("rst_mid_ready", 32'(ready), 32'd1);
    check("rst_mid_ad_oe", 32'(dut.ad_oe), 32'd0);
    cyc();
    rst = 1'b0;
    end_cycle();

    // back-to-back: second ale during FINISH
    latch(20'hF0034, 1'b0);
    start_read();
    run_access(0, 8'h11, low_c, stb_c, err_c);
    check("b2b_ad1", 32'(ad), 32'h11);
    rd_n = 1'b1; den_n = 1'b1;
    latch(20'hF0035, 1'b0);
    check("b2b_adr2", 32'(mem_adr), 32'hF0035);
    check("b2b_ready", 32'(ready), 32'd1);
    start_read();
    check("b2b_stb", 32'(mem_stb), 32'd1);
    run_access(1, 8'h22, low_c, stb_c, err_c);
    check("b2b_low2", 32'(low_c), 32'd2);
    check("b2b_ad2", 32'(ad), 32'h22);
    end_cycle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/bus_demux_waitgen.md
# bus_demux_waitgen

Downstream system-bus stage for `processor_8088`. It demultiplexes the multiplexed `ad` bus and latches the 20-bit address on `ale`. It converts each 8088 byte cycle (`rd_n`/`wr_n`/`den_n`/`iom`) into a strobe/acknowledge access on the PC memory/IO fabric, returns read data onto `ad`, and generates wait states on `ready`, with a timeout for absent slaves.

## Interface
Parameters:
- `WAIT_MEM`, default 1: minimum `ready`-low cycles for a memory access (≥1)
- `WAIT_IO`, default 2: minimum `ready`-low cycles for an IO access (≥1)
- `TIMEOUT`, default 15: cycles in ACCESS without `mem_ack` before forced termination (> both WAITs, ≤ 255)

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  system clock, all state on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `a`  in  20  CPU address; only `a[19:8]` used
- `ad`  inout  8  multiplexed address/data; this block drives it only for read data
- `ale`  in  1  address latch enable, high for one cycle
- `rd_n`, `wr_n`, `den_n`  in  1 each  CPU strobes, active low
- `iom`  in  1  0 = memory, 1 = IO
- `ready`  out  1  high = cycle may complete; low = wait state
- `mem_adr`  out  20  latched byte address
- `mem_io`  out  1  latched `iom`
- `mem_we`  out  1  1 = write access
- `mem_dat_o`  out  8  write data
- `mem_stb`  out  1  access request, held until ack or timeout
- `mem_dat_i`  in  8  read data, valid with `mem_ack`
- `mem_ack`  in  1  slave acknowledge, single cycle
- `bus_err`  out  1  one-cycle pulse on timeout or protocol error

## Operation
- States: IDLE, LATCHED, ACCESS, FINISH.
- Address latch: in IDLE, LATCHED or FINISH, `ale`=1 at an edge loads `mem_adr <= {a[19:8], ad}` and `mem_io <= iom`, then goes to LATCHED. `ale` in ACCESS is ignored.
- LATCHED, `rd_n`=0 and `den_n`=0: go to ACCESS with `mem_we`=0.
- LATCHED, `wr_n`=0 and `den_n`=0: capture `mem_dat_o <= ad`, go to ACCESS with `mem_we`=1.
- LATCHED, `rd_n` and `wr_n` both 0: `bus_err` pulse, go to IDLE, no access.
- ACCESS:
  - `mem_stb`=1, `ready`=0, 8-bit wait counter `cnt` increments from 0 each cycle.
  - `mem_ack`=1: read captures `rdata <= mem_dat_i`, sets `ack_seen`, and `mem_stb` drops the next cycle.
  - Exit to FINISH when `ack_seen` and `cnt+1 ≥ WAIT` (WAIT selected by `mem_io`). Ack arriving in the same cycle counts.
  - `cnt == TIMEOUT-1` without ack: `mem_stb` drops, `rdata <= 8'hFF`, `bus_err` pulses, go to FINISH.
- FINISH: `ready`=1. `ad` is driven with `rdata` while `rd_n`=0 and `den_n`=0, otherwise Z. Go to IDLE when `rd_n`=`wr_n`=1; a new `ale` goes directly to LATCHED.
- `ad` is never driven in IDLE, LATCHED, ACCESS, or during writes.
- `mem_ack` outside ACCESS, or a second ack in the same access, is ignored.

## Timing
- Reset values: state IDLE, `ready`=1, `mem_stb`=0, `mem_we`=0, `mem_io`=0, `mem_adr`=0, `mem_dat_o`=0, `rdata`=0, `bus_err`=0, `ad`=Z, `cnt`=0, `ack_seen`=0.
- Reset asserted mid-access forces all of the above immediately. `mem_stb` falls without waiting for ack.
- `ready` is registered: it falls the cycle after the strobe edge is sampled in LATCHED.
- `ready` stays low for `max(WAIT, ack latency)` cycles, capped at `TIMEOUT`.
- Zero-latency slave (ack in first ACCESS cycle), WAIT_MEM=1: exactly one `ready`-low cycle.
- `mem_adr`/`mem_we`/`mem_dat_o` are stable for the whole time `mem_stb`=1.
- `bus_err` is high for exactly one cycle per event.

## Test plan
- Memory read, `ale` with `a[19:8]`=12'hF00, `ad`=8'h34, `iom`=0; `rd_n`=0 next cycle; ack with `mem_dat_i`=8'hA5 in first ACCESS cycle. Expect `mem_adr`=20'hF0034, `mem_stb` high 1 cycle, `ready` low 1 cycle, then `ad`=8'hA5 while `rd_n`=0.
- IO write, `iom`=1, `ad`=8'h5A during `wr_n`=0, immediate ack. Expect `mem_we`=1, `mem_dat_o`=8'h5A, `mem_io`=1, `ready` low exactly 2 cycles (WAIT_IO).
- Slow slave, ack 6 cycles after strobe on a memory read. Expect `ready` low 6 cycles and `mem_stb` high 6 cycles, with `rdata` taken from the ack cycle.
- No slave, memory read with no ack. Expect `mem_stb` low after 15 cycles, `bus_err` 1-cycle pulse, `ad`=8'hFF in FINISH.
- Protocol and reset:
  - `rd_n` and `wr_n` both low in LATCHED: expect `bus_err` pulse, no `mem_stb`.
  - `rst` asserted on the 3rd ACCESS cycle: expect `mem_stb`=0, `ready`=1, `ad`=Z immediately.
- Back-to-back: second `ale` (address 20'hF0035) arrives during FINISH. Expect direct entry to LATCHED with the new address and correct second read data.
